code_histogram: RTL and testbench
=================================

Name: code_histogram

Overview:
- Downstream consumer of the 8-bit lookup-code stream: registered counter/loader followed by a case-decoded output of 0x10/0x20/0x30/0x40/0x50.
- Keeps saturating occurrence counters for each legal code plus an "other" bin.
- On request, atomically snapshots and clears the bins, then streams the six results out over a valid/ready interface.
- Counting continues uninterrupted during readout.

Parameters:
CNT_W, 16, width of each bin counter and of dump_count (min 2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
code_in  input  8  code from upstream lookup stage
code_valid  input  1  code_in is sampled this cycle when high
dump_req  input  1  request snapshot+readout; accepted only in IDLE
dump_valid  output  1  dump_bin/dump_count valid
dump_ready  input  1  consumer accepts current entry
dump_bin  output  3  bin index 0..5
dump_count  output  CNT_W  snapshot count for dump_bin
dump_last  output  1  high with bin 5 entry
busy  output  1  high while state is DUMP

Behaviour:
- Bin map:
  - 0x10→0, 0x20→1, 0x30→2, 0x40→3, 0x50→4.
  - Any other value→5 (other).
- Counting:
  - Each cycle with code_valid=1, the mapped bin increments by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - The count is visible in the snapshot taken one cycle or more after sampling.
- Reset:
  - While rst is high, all counters and snapshots are 0 and the FSM is in IDLE.
  - dump_valid=0, dump_bin=0, dump_count=0, dump_last=0, busy=0.
  - rst mid-dump abandons the readout; no further dump_valid.
- FSM states: IDLE, DUMP.
- IDLE, dump_req=1 (accept cycle):
  - All six counters are copied into the snapshot registers and the counters are set to 0.
  - If code_valid=1 in the same cycle, the new code counts into the freshly cleared counter, so that bin = 1 afterwards and the code is not in the snapshot.
  - Next state DUMP, index=0.
- DUMP:
  - dump_valid=1 from the cycle after acceptance.
  - dump_bin=index, dump_count=snapshot[index], dump_last=(index==5).
  - Outputs are registered and stay stable while dump_ready=0.
- Handshake:
  - A transfer occurs on a cycle with dump_valid&dump_ready.
  - index increments on each transfer.
  - A transfer with index==5 returns to IDLE; dump_valid=0 the next cycle.
- Back-to-back: dump_req is ignored (not queued) while busy=1. It is accepted at earliest the cycle after busy falls.
- Throughput: with dump_ready held high, a full dump takes 6 consecutive valid cycles, 7 cycles from acceptance to IDLE.
- Counting in DUMP proceeds normally into the live counters and does not affect snapshots.

Optional Feature:
HIST_OVF_FLAG_EN
- Defined:
  - Adds output dump_ovf (1 bit), valid with dump_valid.
  - Each bin has a sticky flag, set when an increment is attempted while the counter is at 2^CNT_W-1.
  - Flags are snapshotted and cleared with the counters at dump acceptance; dump_ovf = snapshot flag of dump_bin.
  - dump_ovf resets to 0.
- Undefined: port and flags are absent; saturation is silent.

Test Plan:
- Reset then codes 0x10,0x10,0x20,0x50,0x07,0x30 with valid, then dump_req with dump_ready=1 → bins 0..5 = 2,1,1,0,1,1; dump_last only on bin 5; busy high 6 cycles.
- code_valid=0 with code_in=0x10 for 10 cycles then dump → all six counts 0.
- CNT_W=2:
  - Feed 0x40 five times, then dump → bin3=3 (saturated), others 0.
  - With HIST_OVF_FLAG_EN → dump_ovf=1 on bin3 only.
  - Second dump → bin3=0, dump_ovf=0.
- dump_req in same cycle as code 0x20, then 0x20 during DUMP, then second dump → first dump bin1=0; second dump bin1=2.
- Hold dump_ready=0 for 4 cycles at bin 2 → dump_bin=2 and dump_count stay stable; dump_req pulses during DUMP are ignored; exactly 6 transfers.
- Assert rst while index=3 → next cycle dump_valid=0, busy=0; a following dump reports all zeros.

Source files
------------

// File: rtl/code_histogram_if.sv
// Bundle for code_histogram: the incoming code stream, the dump request and the dump readout stream.
// The dump_ovf field exists only when HIST_OVF_FLAG_EN is defined.
interface code_histogram_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       code_in;
  logic             code_valid;
  logic             dump_req;
  logic             dump_valid;
  logic             dump_ready;
  logic [2:0]       dump_bin;
  logic [CNT_W-1:0] dump_count;
  logic             dump_last;
  logic             busy;
`ifdef HIST_OVF_FLAG_EN
  logic             dump_ovf;
`endif

  // master: upstream code source plus dump consumer; slave: the histogram itself
`ifdef HIST_OVF_FLAG_EN
  modport master (
    output code_in, code_valid, dump_req, dump_ready,
    input  dump_valid, dump_bin, dump_count, dump_last, busy, dump_ovf
  );
  modport slave (
    input  code_in, code_valid, dump_req, dump_ready,
    output dump_valid, dump_bin, dump_count, dump_last, busy, dump_ovf
  );
`else
  modport master (
    output code_in, code_valid, dump_req, dump_ready,
    input  dump_valid, dump_bin, dump_count, dump_last, busy
  );
  modport slave (
    input  code_in, code_valid, dump_req, dump_ready,
    output dump_valid, dump_bin, dump_count, dump_last, busy
  );
`endif
endinterface

// File: rtl/code_histogram.sv
// Saturating histogram of lookup codes with an atomic snapshot-and-clear, then a six-entry valid/ready readout.
// Optional sticky per-bin overflow flags when HIST_OVF_FLAG_EN is defined.
module code_histogram #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  code_histogram_if.slave  bus
);
  // Readout handshake: an entry moves on any cycle where dump_valid and dump_ready are both high;
  // dump_valid never drops and the entry never changes until that transfer happens.
  typedef enum logic {IDLE, DUMP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [2:0]       index;
  logic [CNT_W-1:0] cnt  [6];
  logic [CNT_W-1:0] snap [6];
  logic [2:0]       code_bin;
  logic [2:0]       next_index;
  logic             accept;
  logic             xfer;

  logic             valid_r;
  logic [2:0]       bin_r;
  logic [CNT_W-1:0] count_r;
  logic             last_r;
  logic             busy_r;

  always_comb begin
    code_bin = 3'd5;
    case (bus.code_in)
      8'h10:   code_bin = 3'd0;
      8'h20:   code_bin = 3'd1;
      8'h30:   code_bin = 3'd2;
      8'h40:   code_bin = 3'd3;
      8'h50:   code_bin = 3'd4;
      default: code_bin = 3'd5;
    endcase
  end

  assign accept     = (state == IDLE) && bus.dump_req;
  assign xfer       = valid_r && bus.dump_ready;
  assign next_index = index + 3'd1;

  // On acceptance the live counters restart from zero, so a code arriving that
  // same cycle lands in the new interval rather than the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (accept) begin
          snap[i] <= cnt[i];
          cnt[i]  <= (bus.code_valid && code_bin == 3'(i)) ? CNT_ONE : '0;
        end else if (bus.code_valid && code_bin == 3'(i) && cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef HIST_OVF_FLAG_EN
  logic [5:0] ovf_flag;
  logic [5:0] ovf_snap;
  logic       ovf_r;

  // A cleared counter can never be at max, so the accept-cycle code cannot raise a flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= '0;
      ovf_snap <= '0;
    end else if (accept) begin
      ovf_snap <= ovf_flag;
      ovf_flag <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (bus.code_valid && code_bin == 3'(i) && cnt[i] == CNT_MAX)
          ovf_flag[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (accept) begin
      ovf_r <= ovf_flag[0];
    end else if (xfer) begin
      ovf_r <= (index == 3'd5) ? 1'b0 : ovf_snap[next_index];
    end
  end

  assign bus.dump_ovf = ovf_r;
`endif

  // The first entry is loaded straight from the live counters because the
  // snapshot registers are being written on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      index   <= 3'd0;
      valid_r <= 1'b0;
      bin_r   <= 3'd0;
      count_r <= '0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            state   <= DUMP;
            index   <= 3'd0;
            valid_r <= 1'b1;
            bin_r   <= 3'd0;
            count_r <= cnt[0];
            last_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        DUMP: begin
          if (xfer) begin
            if (index == 3'd5) begin
              state   <= IDLE;
              index   <= 3'd0;
              valid_r <= 1'b0;
              bin_r   <= 3'd0;
              count_r <= '0;
              last_r  <= 1'b0;
              busy_r  <= 1'b0;
            end else begin
              index   <= next_index;
              bin_r   <= next_index;
              count_r <= snap[next_index];
              last_r  <= (next_index == 3'd5);
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dump_valid = valid_r;
  assign bus.dump_bin   = bin_r;
  assign bus.dump_count = count_r;
  assign bus.dump_last  = last_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_code_histogram.sv
// Directed bench for code_histogram at CNT_W=2 so saturation is reachable in a few codes.
// Expected counts are hand-computed per scenario and queued ahead of each dump.
module tb_code_histogram;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_histogram_if #(.CNT_W(CNT_W)) bus ();

  code_histogram #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      bus.code_in    = c;
      bus.code_valid = 1'b1;
      tick();
    end
    bus.code_valid = 1'b0;
  endtask

  task automatic push6(input int a, input int b, input int c, input int d, input int e, input int f);
    exp_q.push_back(CNT_W'(a));
    exp_q.push_back(CNT_W'(b));
    exp_q.push_back(CNT_W'(c));
    exp_q.push_back(CNT_W'(d));
    exp_q.push_back(CNT_W'(e));
    exp_q.push_back(CNT_W'(f));
  endtask

  // Requests a dump and walks all six entries; optional stall at one entry,
  // a 0x20 code in the accept cycle, and a 0x20 code during the first transfer.
  task automatic run_dump(input int stall_at, input bit same20, input bit inject20,
                          input logic [5:0] ovf_mask);
    logic [CNT_W-1:0] e;
    if (same20) begin
      bus.code_in    = 8'h20;
      bus.code_valid = 1'b1;
    end
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req   = 1'b0;
    bus.code_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'd1, 32'd0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      if (k == stall_at) begin
        bus.dump_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          bus.dump_req = (s % 2 == 0);
          tick();
          check("stall_valid", 32'(bus.dump_valid), 32'd1);
          check("stall_bin", 32'(bus.dump_bin), 32'(k));
          check("stall_count", 32'(bus.dump_count), 32'(e));
        end
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b1;
      end
      check("valid", 32'(bus.dump_valid), 32'd1);
      check("busy", 32'(bus.busy), 32'd1);
      check("bin", 32'(bus.dump_bin), 32'(k));
      check("count", 32'(bus.dump_count), 32'(e));
      check("last", 32'(bus.dump_last), (k == 5) ? 32'd1 : 32'd0);
`ifdef HIST_OVF_FLAG_EN
      check("ovf", 32'(bus.dump_ovf), 32'(ovf_mask[k]));
`else
      if (ovf_mask[k]) begin end
`endif
      if (inject20 && k == 0) begin
        bus.code_in    = 8'h20;
        bus.code_valid = 1'b1;
      end
      tick();
      bus.code_valid = 1'b0;
    end
    check("end_valid", 32'(bus.dump_valid), 32'd0);
    check("end_busy", 32'(bus.busy), 32'd0);
    tick();
    check("idle_valid", 32'(bus.dump_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.code_in    = 8'h00;
    bus.code_valid = 1'b0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_bin", 32'(bus.dump_bin), 32'd0);
    check("rst_count", 32'(bus.dump_count), 32'd0);
    check("rst_last", 32'(bus.dump_last), 32'd0);
    rst = 1'b0;
    tick();

    // Basic mapping including an "other" code.
    send_code(8'h10, 2);
    send_code(8'h20, 1);
    send_code(8'h50, 1);
    send_code(8'h07, 1);
    send_code(8'h30, 1);
    push6(2, 1, 1, 0, 1, 1);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    // Codes presented without code_valid are not counted.
    bus.code_in = 8'h10;
    for (int i = 0; i < 10; i++) tick();
    push6(0, 0, 0, 0, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    // Exactly reaching max does not flag overflow.
    send_code(8'h40, 3);
    push6(0, 0, 0, 3, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    // Saturation with overflow, then a clean follow-up dump.
    send_code(8'h40, 5);
    push6(0, 0, 0, 3, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b001000);
    push6(0, 0, 0, 0, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    // Accept-cycle code and a code during readout land in the next interval.
    push6(0, 0, 0, 0, 0, 0);
    run_dump(-1, 1'b1, 1'b1, 6'b000000);
    push6(0, 2, 0, 0, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    // Backpressure on bin 2 with ignored dump_req pulses.
    send_code(8'h30, 2);
    send_code(8'h50, 2);
    send_code(8'h99, 1);
    push6(0, 0, 2, 0, 2, 1);
    run_dump(2, 1'b0, 1'b0, 6'b000000);

    // Reset in the middle of a readout.
    send_code(8'h10, 2);
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req   = 1'b0;
    bus.code_in    = 8'h30;
    bus.code_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.code_valid = 1'b0;
    check("mid_bin", 32'(bus.dump_bin), 32'd3);
    check("mid_valid", 32'(bus.dump_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(bus.dump_valid), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_count", 32'(bus.dump_count), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_after", 32'(bus.dump_valid), 32'd0);
    push6(0, 0, 0, 0, 0, 0);
    run_dump(-1, 1'b0, 1'b0, 6'b000000);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
